victim_buffer: RTL and testbench
================================

// Module: victim_buffer
// PURPOSE
//  Fully associative victim buffer between the L2 cache and physical memory. Entries are vc_t
//  (line address + line). Holds dirty lines evicted by L2 (upstream writes) and serves later
//  L2 reads that hit them. Lines go to pmem only when an entry must be displaced.
//  Read misses pass through to pmem and are not allocated.
// PARAMETERS
//  NUM_ENTRIES  4    number of vc_t entries; power of two, >=2
//  LINE_W       256  cache line width in bits (rv32i_cache_line)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  mem_read      in   1       L2 line read request; held until mem_resp
//  mem_write     in   1       L2 line writeback (eviction); held until mem_resp
//  mem_address   in   32      line address; bits [4:0] ignored
//  mem_wdata     in   LINE_W  writeback line
//  mem_rdata     out  LINE_W  read line; valid while mem_resp=1
//  mem_resp      out  1       one-cycle completion pulse to L2
//  pmem_read     out  1       pmem line read; held until pmem_resp
//  pmem_write    out  1       pmem line write; held until pmem_resp
//  pmem_address  out  32      pmem line address; bits [4:0] = 0
//  pmem_wdata    out  LINE_W  line written to pmem
//  pmem_rdata    in   LINE_W  pmem read data; valid with pmem_resp
//  pmem_resp     in   1       pmem completion, one cycle
// BEHAVIOUR
//  - Reset (async): state=IDLE; all valid bits and ages =0; all outputs 0. Reset mid-transaction
//    drops pmem_read/pmem_write at once. The in-flight request is discarded without mem_resp.
//  - All outputs are registered. Each entry holds valid, age[log2 N], vc_t{address[31:5],5'b0; data}.
//  - Tag compare: mem_address[31:5] against valid entries only. Address bits [4:0] are ignored.
//  - If mem_read and mem_write are both 1, the request is treated as a write. A write wins.
//  - FSM states: IDLE, WB, FILL, RESP. Requests are sampled only in IDLE.
//  - IDLE, read hit: mem_rdata <= entry data; touch the entry; go to RESP.
//  - IDLE, read miss: pmem_read<=1, pmem_address<=line addr; go to FILL.
//  - IDLE, write hit: overwrite the entry data; touch it; go to RESP.
//  - IDLE, write miss with a free entry: allocate the lowest-index invalid entry; touch it; go to RESP.
//  - IDLE, write miss with all entries full: pmem_write<=1; pmem_address/pmem_wdata <= LRU entry; go to WB.
//  - FILL: hold outputs until pmem_resp. On that edge: mem_rdata<=pmem_rdata, pmem_read<=0, go to RESP.
//    No allocation occurs.
//  - WB: hold until pmem_resp. On that edge: the LRU entry is replaced by the incoming line and
//    touched; pmem_write<=0; go to RESP.
//  - RESP: mem_resp=1 for exactly one cycle, then IDLE. L2 deasserts its request on seeing mem_resp,
//    so IDLE never resamples a completed request.
//  - Latency, hit or allocating write: mem_resp is high in the cycle after the request is first seen in IDLE.
//  - Latency, miss/WB: mem_resp is high in the cycle after the pmem_resp edge.
//  - LRU touch of entry i with prior age a: an invalid entry counts as a=NUM_ENTRIES-1. Every valid
//    entry with age<a increments; entry i gets age 0. Ages stay a permutation over valid entries.
//    The victim is the valid entry with age NUM_ENTRIES-1.
//  - pmem_read and pmem_write are never high together. pmem outputs are stable while awaiting pmem_resp.
//  - mem_rdata holds its last value outside RESP. Content outside RESP is don't-care.
// TESTING
//  1 Reset, then read 0x0000_1000 -> pmem_read=1, pmem_address=0x0000_1000. Drive pmem_resp with
//    rdata D -> next cycle mem_resp=1, mem_rdata=D. Repeat the read -> pmem_read again (no allocation).
//  2 Write 0x100 with data {8{32'hAAAA_AAAA}} -> mem_resp 1 cycle later, no pmem activity.
//    Read 0x104 -> hit, mem_rdata={8{32'hAAAA_AAAA}}, pmem_read stays 0.
//  3 Write 0x000, 0x020, 0x040, 0x060 (data D0-D3); read 0x000; write 0x080 ->
//    pmem_write=1, pmem_address=0x020, pmem_wdata=D1. After pmem_resp, mem_resp=1.
//    Read 0x020 -> pmem miss; read 0x080 -> hit.
//  4 Write hit: overwrite 0x040 with D9 -> no pmem, mem_resp next cycle. Read 0x040 -> mem_rdata=D9.
//    The LRU victim is now 0x060.
//  5 Assert rst while in WB with pmem_write=1 -> pmem_write=0 and mem_resp=0 immediately.
//    After release, read 0x000 -> pmem_read (entries cleared).
//  6 mem_read and mem_write both 1 to 0x200 -> handled as a write: allocated, no pmem_read.
//    A later read of 0x200 hits.

Source files
------------

// File: rtl/victim_buffer.sv
// Fully associative victim buffer between L2 and physical memory: holds dirty
// lines evicted by L2, serves L2 reads that hit them, and spills LRU lines to pmem.
module victim_buffer #(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned LINE_W      = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       mem_address,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int unsigned IW = $clog2(NUM_ENTRIES);

   typedef logic [IW-1:0] idx_t;
   typedef logic [NUM_ENTRIES-1:0][IW-1:0] age_vec_t;

   typedef struct packed {
      logic [31:0]       address;
      logic [LINE_W-1:0] data;
   } vc_t;

   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

   state_t                 state;
   logic [NUM_ENTRIES-1:0] valid;
   age_vec_t               age;
   vc_t                    entry [NUM_ENTRIES];
   logic [31:0]            req_addr;
   logic [LINE_W-1:0]      req_data;
   idx_t                   victim;

   logic [31:0] line_addr;
   logic        hit;
   idx_t        hit_idx;
   logic        free;
   idx_t        free_idx;
   idx_t        lru_idx;
   logic        unused_offset;

   assign line_addr     = {mem_address[31:5], 5'b0};
   assign unused_offset = ^mem_address[4:0];

   // Tag match, lowest free slot and LRU victim, over valid entries only
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      lru_idx  = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         if (valid[i] && entry[i].address[31:5] == mem_address[31:5]) begin
            hit     = 1'b1;
            hit_idx = idx_t'(i);
         end
         if (!valid[i] && !free) begin
            free     = 1'b1;
            free_idx = idx_t'(i);
         end
         if (valid[i] && age[i] == idx_t'(NUM_ENTRIES - 1)) begin
            lru_idx = idx_t'(i);
         end
      end
   end

   // Make idx most recent; an invalid slot is treated as the oldest age
   function automatic age_vec_t touched(input age_vec_t ages,
                                        input logic [NUM_ENTRIES-1:0] vld,
                                        input idx_t idx);
      idx_t a;
      a = vld[idx] ? ages[idx] : idx_t'(NUM_ENTRIES - 1);
      touched = ages;
      for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
         if (vld[j] && ages[j] < a) begin
            touched[j] = ages[j] + idx_t'(1);
         end
      end
      touched[idx] = '0;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         valid        <= '0;
         age          <= '0;
         mem_rdata    <= '0;
         mem_resp     <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         req_addr     <= '0;
         req_data     <= '0;
         victim       <= '0;
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            entry[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               mem_resp <= 1'b0;
               if (mem_write) begin
                  req_addr <= line_addr;
                  req_data <= mem_wdata;
                  if (hit) begin
                     entry[hit_idx].data <= mem_wdata;
                     age      <= touched(age, valid, hit_idx);
                     mem_resp <= 1'b1;
                     state    <= RESP;
                  end else if (free) begin
                     entry[free_idx]  <= '{address: line_addr, data: mem_wdata};
                     valid[free_idx]  <= 1'b1;
                     age      <= touched(age, valid, free_idx);
                     mem_resp <= 1'b1;
                     state    <= RESP;
                  end else begin
                     // Full: spill the LRU line before the incoming line replaces it
                     pmem_write   <= 1'b1;
                     pmem_address <= entry[lru_idx].address;
                     pmem_wdata   <= entry[lru_idx].data;
                     victim       <= lru_idx;
                     state        <= WB;
                  end
               end else if (mem_read) begin
                  if (hit) begin
                     mem_rdata <= entry[hit_idx].data;
                     age       <= touched(age, valid, hit_idx);
                     mem_resp  <= 1'b1;
                     state     <= RESP;
                  end else begin
                     pmem_read    <= 1'b1;
                     pmem_address <= line_addr;
                     state        <= FILL;
                  end
               end
            end
            FILL: begin
               if (pmem_resp) begin
                  mem_rdata <= pmem_rdata;
                  pmem_read <= 1'b0;
                  mem_resp  <= 1'b1;
                  state     <= RESP;
               end
            end
            WB: begin
               if (pmem_resp) begin
                  entry[victim] <= '{address: req_addr, data: req_data};
                  age        <= touched(age, valid, victim);
                  pmem_write <= 1'b0;
                  mem_resp   <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               mem_resp <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_victim_buffer.sv
// Scoreboard bench for victim_buffer: a queue/LRU-list reference model predicts
// pmem traffic and L2 responses; separate monitors pop and compare.
module tb_victim_buffer;

   localparam int unsigned N  = 4;
   localparam int unsigned LW = 256;

   typedef logic [LW-1:0] line_t;

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      line_t       data;
   } pop_t;

   typedef struct {
      bit    is_read;
      line_t data;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_address = '0;
   line_t       mem_wdata = '0;
   line_t       mem_rdata;
   logic        mem_resp;
   logic        pmem_read;
   logic        pmem_write;
   logic [31:0] pmem_address;
   line_t       pmem_wdata;
   line_t       pmem_rdata = '0;
   logic        pmem_resp = 1'b0;

   always #5 clk = ~clk;

   victim_buffer #(.NUM_ENTRIES(N), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_line(input string name, input line_t got, input line_t exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   // Reference model: line contents by line number, recency list (front = newest)
   line_t       ref_data [int unsigned];
   int unsigned ref_lru  [$];
   line_t       ref_pmem [int unsigned];
   line_t       pm_mem   [int unsigned];
   pop_t        pmem_exp [$];
   resp_t       resp_exp [$];
   bit          pmem_auto = 1'b1;

   function automatic line_t pmem_init(input int unsigned ln);
      return {8{ln ^ 32'h5A5A_0000}};
   endfunction

   function automatic line_t rand_line();
      line_t l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic void ref_touch(input int unsigned ln);
      for (int k = 0; k < ref_lru.size(); k++) begin
         if (ref_lru[k] == ln) begin
            ref_lru.delete(k);
            break;
         end
      end
      ref_lru.push_front(ln);
   endfunction

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input line_t wd);
      int unsigned ln;
      int unsigned vic;
      bit          fast;
      resp_t       r;
      pop_t        p;
      int          cnt;
      bit          got;
      ln   = int'(addr >> 5);
      fast = 1'b1;
      if (wr) begin
         r.is_read = 1'b0;
         r.data    = '0;
         if (!ref_data.exists(ln) && ref_lru.size() == N) begin
            vic        = ref_lru.pop_back();
            p.is_write = 1'b1;
            p.addr     = 32'(vic) << 5;
            p.data     = ref_data[vic];
            pmem_exp.push_back(p);
            ref_pmem[vic] = ref_data[vic];
            ref_data.delete(vic);
            fast = 1'b0;
         end
         ref_data[ln] = wd;
         ref_touch(ln);
      end else begin
         r.is_read = 1'b1;
         if (ref_data.exists(ln)) begin
            r.data = ref_data[ln];
            ref_touch(ln);
         end else begin
            p.is_write = 1'b0;
            p.addr     = 32'(ln) << 5;
            p.data     = '0;
            pmem_exp.push_back(p);
            r.data = ref_pmem.exists(ln) ? ref_pmem[ln] : pmem_init(ln);
            fast   = 1'b0;
         end
      end
      resp_exp.push_back(r);
      mem_read    = rd;
      mem_write   = wr;
      mem_address = addr;
      mem_wdata   = wd;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 100) begin
         @(negedge clk);
         cnt++;
         got = mem_resp;
      end
      check_bit("mem_resp arrives", got, 1'b1);
      if (got && fast) check32("hit/alloc latency", 32'(cnt), 32'd1);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_wdata = rand_line();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_bit("reset mem_resp", mem_resp, 1'b0);
      check_bit("reset pmem_read", pmem_read, 1'b0);
      check_bit("reset pmem_write", pmem_write, 1'b0);
      check32("reset pmem_address", pmem_address, 32'h0);
      check_line("reset pmem_wdata", pmem_wdata, '0);
      check_line("reset mem_rdata", mem_rdata, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      ref_data.delete();
      ref_lru.delete();
      pmem_exp.delete();
      resp_exp.delete();
      @(negedge clk);
   endtask

   // Response monitor: every mem_resp pops one expected L2 response
   resp_t mon_r;
   logic  mon_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst && mem_resp) begin
         check_bit("mem_resp single pulse", mon_prev, 1'b0);
         if (resp_exp.size() == 0) begin
            check_bit("unexpected mem_resp", 1'b1, 1'b0);
         end else begin
            mon_r = resp_exp.pop_front();
            if (mon_r.is_read) check_line("mem_rdata", mem_rdata, mon_r.data);
         end
      end
      mon_prev = !rst && mem_resp;
   end

   // pmem responder: checks each request against the model, then completes it
   initial begin
      pop_t        cur;
      bit          have;
      int          lat;
      int unsigned a;
      forever begin
         @(negedge clk);
         pmem_rdata = rand_line();
         if (!rst && pmem_auto && (pmem_read || pmem_write)) begin
            check_bit("pmem read/write exclusive", pmem_read & pmem_write, 1'b0);
            have = pmem_exp.size() != 0;
            if (!have) check_bit("unexpected pmem request", 1'b1, 1'b0);
            else cur = pmem_exp.pop_front();
            lat = int'($urandom_range(0, 3));
            for (int k = 0; k <= lat; k++) begin
               if (have) begin
                  check_bit("pmem_read", pmem_read, !cur.is_write);
                  check_bit("pmem_write", pmem_write, cur.is_write);
                  check32("pmem_address", pmem_address, cur.addr);
                  if (cur.is_write) check_line("pmem_wdata", pmem_wdata, cur.data);
               end
               if (k < lat) @(negedge clk);
            end
            a = int'(pmem_address >> 5);
            if (pmem_write) pm_mem[a] = pmem_wdata;
            else pmem_rdata = pm_mem.exists(a) ? pm_mem[a] : pmem_init(a);
            pmem_resp = 1'b1;
            @(negedge clk);
            pmem_resp = 1'b0;
            check_bit("mem_resp after pmem_resp", mem_resp, 1'b1);
            check_bit("pmem released", pmem_read | pmem_write, 1'b0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wait_cnt;
      int unsigned ln;
      int unsigned kind;
      line_t       d [4];

      for (int k = 0; k < 4; k++) d[k] = rand_line();

      @(negedge clk);
      do_reset();

      // Read miss passes through and does not allocate
      do_req(1'b1, 1'b0, 32'h0000_1000, rand_line());
      do_req(1'b1, 1'b0, 32'h0000_1000, rand_line());

      // Allocating write then hit with a different offset
      do_req(1'b0, 1'b1, 32'h0000_0100, {8{32'hAAAA_AAAA}});
      do_req(1'b1, 1'b0, 32'h0000_0104, rand_line());

      // Fill, touch, then eviction of the LRU line (0x020)
      do_reset();
      for (int k = 0; k < 4; k++) do_req(1'b0, 1'b1, 32'(k) << 5, d[k]);
      do_req(1'b1, 1'b0, 32'h0000_0000, rand_line());
      do_req(1'b0, 1'b1, 32'h0000_0080, rand_line());
      do_req(1'b1, 1'b0, 32'h0000_0020, rand_line());
      do_req(1'b1, 1'b0, 32'h0000_0080, rand_line());

      // Write hit, read back, then 0x060 is the next victim
      do_req(1'b0, 1'b1, 32'h0000_0040, {8{32'h9999_0009}});
      do_req(1'b1, 1'b0, 32'h0000_0040, rand_line());
      do_req(1'b0, 1'b1, 32'h0000_00A0, rand_line());

      // Reset while a writeback is outstanding
      do_reset();
      for (int k = 0; k < 4; k++) do_req(1'b0, 1'b1, 32'(k) << 5, d[k]);
      pmem_auto   = 1'b0;
      mem_write   = 1'b1;
      mem_address = 32'h0000_0080;
      mem_wdata   = rand_line();
      wait_cnt = 0;
      while (!pmem_write && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      check_bit("writeback started", pmem_write, 1'b1);
      check32("writeback address", pmem_address, 32'h0000_0000);
      check_line("writeback data", pmem_wdata, d[0]);
      rst = 1'b1;
      #1;
      check_bit("pmem_write dropped by reset", pmem_write, 1'b0);
      check_bit("no mem_resp on reset", mem_resp, 1'b0);
      mem_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      pmem_auto = 1'b1;
      do_reset();
      do_req(1'b1, 1'b0, 32'h0000_0000, rand_line());

      // Simultaneous read and write is a write
      do_req(1'b1, 1'b1, 32'h0000_0200, {8{32'h0200_CAFE}});
      do_req(1'b1, 1'b0, 32'h0000_0200, rand_line());

      // Random traffic over a small set of lines to exercise hits, misses and spills
      do_reset();
      for (int i = 0; i < 400; i++) begin
         ln   = $urandom_range(0, 9);
         kind = $urandom_range(0, 3);
         do_req(kind != 2 ? (kind != 3 ? 1'b1 : 1'b1) & (kind != 2) : 1'b0,
                kind >= 2,
                32'h0000_4000 + (32'(ln) << 5) + 32'($urandom_range(0, 31)),
                rand_line());
      end

      repeat (5) @(negedge clk);
      check32("responses outstanding", 32'(resp_exp.size()), 32'd0);
      check32("pmem requests outstanding", 32'(pmem_exp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
